stream_checker: RTL and testbench

Synthesizable valid/ready stream sink that terminates the downstream end of a skid-buffered pipeline. It drives `ready_in` with a programmable periodic backpressure pattern. It checks that accepted beats form an incrementing sequence 0,1,2,… and enforces the hold rules of the valid/ready protocol. It then reports pass/fail, so that skid buffer and pipeline stages can be self-checked in hardware without a simulation scoreboard.

---
 rtl/stream_checker.sv | 139 +++++++++++++
 tb/tb_stream_checker.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_checker.sv
// Valid/ready stream sink: drives a periodic ready pattern, checks for an incrementing
// beat sequence and valid/ready hold rules, and reports pass/fail with diagnostics.
module stream_checker #(
  parameter int DATA_WIDTH  = 8,
  parameter int TOTAL_BEATS = 20,
  parameter int READY_ON    = 4,
  parameter int READY_OFF   = 3,
  parameter int CNT_WIDTH   = 16,
  parameter int TIMEOUT     = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  valid_in,
  output logic                  ready_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [1:0]            err_code,
  output logic [DATA_WIDTH-1:0] err_got,
  output logic [DATA_WIDTH-1:0] err_exp,
  output logic [CNT_WIDTH-1:0]  recv_cnt,
  output logic [CNT_WIDTH-1:0]  stall_cnt
);

  localparam int PERIOD = READY_ON + READY_OFF;
  // Phase is wide enough to hold PERIOD itself so READY_ON never truncates.
  localparam int PW     = $clog2(PERIOD + 1);
  localparam int TW     = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE, ST_FAIL} state_t;

  state_t                r_state;
  logic [PW-1:0]         r_phase;
  logic [CNT_WIDTH-1:0]  r_exp;
  logic [CNT_WIDTH-1:0]  r_recv;
  logic [CNT_WIDTH-1:0]  r_stall;
  logic [TW-1:0]         r_tmo;
  logic                  r_hold;
  logic [DATA_WIDTH-1:0] r_hold_data;
  logic [1:0]            r_err_code;
  logic [DATA_WIDTH-1:0] r_err_got;
  logic [DATA_WIDTH-1:0] r_err_exp;

  logic                  w_hs;
  logic                  w_match;
  logic                  w_proto_err;
  logic                  w_phase_last;
  logic [CNT_WIDTH-1:0]  w_recv_nxt;
  logic [TW-1:0]         w_tmo_nxt;

  assign ready_in     = (r_state == ST_RUN) && (r_phase < PW'(READY_ON));
  assign w_hs         = valid_in && ready_in;
  assign w_match      = (data_in == r_exp[DATA_WIDTH-1:0]);
  assign w_proto_err  = r_hold && (!valid_in || (data_in != r_hold_data));
  assign w_phase_last = (r_phase == PW'(PERIOD - 1));
  assign w_recv_nxt   = r_recv + 1'b1;
  assign w_tmo_nxt    = r_tmo + 1'b1;

  assign busy      = (r_state == ST_RUN);
  assign done      = (r_state == ST_DONE);
  assign error     = (r_state == ST_FAIL);
  assign err_code  = r_err_code;
  assign err_got   = r_err_got;
  assign err_exp   = r_err_exp;
  assign recv_cnt  = r_recv;
  assign stall_cnt = r_stall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_phase     <= '0;
      r_exp       <= '0;
      r_recv      <= '0;
      r_stall     <= '0;
      r_tmo       <= '0;
      r_hold      <= 1'b0;
      r_hold_data <= '0;
      r_err_code  <= 2'd0;
      r_err_got   <= '0;
      r_err_exp   <= '0;
    end else begin
      case (r_state)
        ST_RUN: begin
          r_phase     <= w_phase_last ? '0 : r_phase + 1'b1;
          r_hold      <= valid_in && !ready_in;
          r_hold_data <= data_in;
          if (valid_in && !ready_in && (r_stall != '1)) begin
            r_stall <= r_stall + 1'b1;
          end
          if (w_proto_err) begin
            r_state    <= ST_FAIL;
            r_err_code <= 2'd2;
            r_err_got  <= data_in;
            r_err_exp  <= r_hold_data;
          end else if (w_hs && !w_match) begin
            r_state    <= ST_FAIL;
            r_err_code <= 2'd1;
            r_err_got  <= data_in;
            r_err_exp  <= r_exp[DATA_WIDTH-1:0];
          end else if (w_hs) begin
            r_exp  <= r_exp + 1'b1;
            r_recv <= w_recv_nxt;
            r_tmo  <= '0;
            if (w_recv_nxt == CNT_WIDTH'(TOTAL_BEATS)) begin
              r_state <= ST_DONE;
            end
          end else begin
            r_tmo <= w_tmo_nxt;
            if (w_tmo_nxt == TW'(TIMEOUT)) begin
              r_state    <= ST_FAIL;
              r_err_code <= 2'd3;
              r_err_got  <= data_in;
              r_err_exp  <= r_exp[DATA_WIDTH-1:0];
            end
          end
        end
        default: begin
          // IDLE, DONE and FAIL hold results until the next start.
          if (start) begin
            r_state     <= ST_RUN;
            r_phase     <= '0;
            r_exp       <= '0;
            r_recv      <= '0;
            r_stall     <= '0;
            r_tmo       <= '0;
            r_hold      <= 1'b0;
            r_hold_data <= '0;
            r_err_code  <= 2'd0;
            r_err_got   <= '0;
            r_err_exp   <= '0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stream_checker.sv
// Directed self-checking bench for stream_checker: default, short-timeout and
// narrow-data/always-ready configurations.
module tb_stream_checker;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Default-parameter instance.
  logic d_start = 1'b0, d_valid = 1'b0, d_ready, d_busy, d_done, d_error;
  logic [7:0] d_data = 8'd0, d_got, d_exp;
  logic [1:0] d_code;
  logic [15:0] d_recv, d_stall;

  // TIMEOUT=16 instance.
  logic t_start = 1'b0, t_valid = 1'b0, t_ready, t_busy, t_done, t_error;
  logic [7:0] t_data = 8'd0, t_got, t_exp;
  logic [1:0] t_code;
  logic [15:0] t_recv, t_stall;

  // DATA_WIDTH=4, TOTAL_BEATS=40, READY_OFF=0 instance.
  logic w_start = 1'b0, w_valid = 1'b0, w_ready, w_busy, w_done, w_error;
  logic [3:0] w_data = 4'd0, w_got, w_exp;
  logic [1:0] w_code;
  logic [15:0] w_recv, w_stall;

  stream_checker u_def (
    .clk(clk), .reset(reset), .start(d_start), .valid_in(d_valid), .ready_in(d_ready),
    .data_in(d_data), .busy(d_busy), .done(d_done), .error(d_error), .err_code(d_code),
    .err_got(d_got), .err_exp(d_exp), .recv_cnt(d_recv), .stall_cnt(d_stall)
  );

  stream_checker #(.TIMEOUT(16)) u_tmo (
    .clk(clk), .reset(reset), .start(t_start), .valid_in(t_valid), .ready_in(t_ready),
    .data_in(t_data), .busy(t_busy), .done(t_done), .error(t_error), .err_code(t_code),
    .err_got(t_got), .err_exp(t_exp), .recv_cnt(t_recv), .stall_cnt(t_stall)
  );

  stream_checker #(.DATA_WIDTH(4), .TOTAL_BEATS(40), .READY_OFF(0)) u_w4 (
    .clk(clk), .reset(reset), .start(w_start), .valid_in(w_valid), .ready_in(w_ready),
    .data_in(w_data), .busy(w_busy), .done(w_done), .error(w_error), .err_code(w_code),
    .err_got(w_got), .err_exp(w_exp), .recv_cnt(w_recv), .stall_cnt(w_stall)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Always-valid incrementing source into u_def; checks the 4-on/3-off ready pattern.
  task automatic run_def(output int k);
    int v;
    logic hs;
    v = 0;
    d_valid = 1'b1;
    d_data = 8'd0;
    d_start = 1'b1;
    tick();
    d_start = 1'b0;
    chk("start_busy", 32'(d_busy), 32'd1);
    chk("start_recv_clr", 32'(d_recv), 32'd0);
    chk("start_code_clr", 32'(d_code), 32'd0);
    k = 0;
    while (!d_done && !d_error && k < 200) begin
      chk("ready_pat", 32'(d_ready), 32'((k % 7) < 4));
      hs = d_valid & d_ready;
      tick();
      if (hs) begin
        v++;
        d_data = 8'(v);
      end
      k++;
    end
  endtask

  logic [7:0] seq [4] = '{8'd0, 8'd1, 8'd2, 8'd7};

  initial begin
    int k;
    int idx;
    int c;
    int v;
    logic hs;

    // Reset state
    tick();
    tick();
    chk("rst_ready", 32'(d_ready), 32'd0);
    chk("rst_busy", 32'(d_busy), 32'd0);
    chk("rst_done", 32'(d_done), 32'd0);
    chk("rst_error", 32'(d_error), 32'd0);
    chk("rst_code", 32'(d_code), 32'd0);
    chk("rst_got", 32'(d_got), 32'd0);
    chk("rst_exp", 32'(d_exp), 32'd0);
    chk("rst_recv", 32'(d_recv), 32'd0);
    chk("rst_stall", 32'(d_stall), 32'd0);
    reset = 1'b0;
    tick();
    chk("idle_ready", 32'(d_ready), 32'd0);
    chk("idle_busy", 32'(d_busy), 32'd0);

    // Clean pass with defaults: last beat accepted at period 5 phase 3 -> 32 cycles.
    run_def(k);
    chk("pass_done", 32'(d_done), 32'd1);
    chk("pass_cycles", k, 32'd32);
    chk("pass_recv", 32'(d_recv), 32'd20);
    chk("pass_code", 32'(d_code), 32'd0);
    chk("pass_busy", 32'(d_busy), 32'd0);
    chk("pass_ready_low", 32'(d_ready), 32'd0);
    chk("pass_stall", 32'(d_stall), 32'd12);

    // Data mismatch: 0,1,2,7
    idx = 0;
    d_valid = 1'b1;
    d_data = seq[0];
    d_start = 1'b1;
    tick();
    d_start = 0;
    chk("mm_recv_clr", 32'(d_recv), 32'd0);
    chk("mm_done_clr", 32'(d_done), 32'd0);
    k = 0;
    while (!d_error && !d_done && k < 20) begin
      hs = d_valid & d_ready;
      tick();
      if (hs) begin
        idx++;
        if (idx < 4) d_data = seq[idx];
      end
      k++;
    end
    chk("mm_error", 32'(d_error), 32'd1);
    chk("mm_cycles", k, 32'd4);
    chk("mm_code", 32'(d_code), 32'd1);
    chk("mm_got", 32'(d_got), 32'd7);
    chk("mm_exp", 32'(d_exp), 32'd3);
    chk("mm_recv", 32'(d_recv), 32'd3);
    chk("mm_ready_low", 32'(d_ready), 32'd0);

    // Protocol: valid dropped while stalled
    d_valid = 1'b1;
    d_data = 8'd0;
    d_start = 1'b1;
    tick();
    d_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      d_data = 8'((i < 4) ? i : 4);
      tick();
    end
    chk("drop_no_err_yet", 32'(d_error), 32'd0);
    d_valid = 1'b0;
    tick();
    chk("drop_error", 32'(d_error), 32'd1);
    chk("drop_code", 32'(d_code), 32'd2);
    chk("drop_recv", 32'(d_recv), 32'd4);
    chk("drop_exp", 32'(d_exp), 32'd4);

    // Protocol: data changes 5->6 while stalled
    d_valid = 1'b1;
    d_data = 8'd0;
    d_start = 1'b1;
    tick();
    d_start = 1'b0;
    for (int i = 0; i < 13; i++) begin
      if (i <= 3) begin
        d_valid = 1'b1; d_data = 8'(i);
      end else if (i <= 7) begin
        d_valid = 1'b1; d_data = 8'd4;
      end else if (i <= 10) begin
        d_valid = 1'b0; d_data = 8'd4;
      end else if (i == 11) begin
        d_valid = 1'b1; d_data = 8'd5;
      end else begin
        d_valid = 1'b1; d_data = 8'd6;
        chk("chg_no_err_yet", 32'(d_error), 32'd0);
      end
      tick();
    end
    chk("chg_error", 32'(d_error), 32'd1);
    chk("chg_code", 32'(d_code), 32'd2);
    chk("chg_got", 32'(d_got), 32'd6);
    chk("chg_exp", 32'(d_exp), 32'd5);
    chk("chg_recv", 32'(d_recv), 32'd5);

    // Timeout with TIMEOUT=16, source never valid
    t_valid = 1'b0;
    t_data = 8'hA5;
    t_start = 1'b1;
    tick();
    t_start = 1'b0;
    chk("tmo_busy", 32'(t_busy), 32'd1);
    c = 0;
    while (!t_error && c < 40) begin
      tick();
      c++;
    end
    chk("tmo_cycles", c, 32'd16);
    chk("tmo_code", 32'(t_code), 32'd3);
    chk("tmo_got", 32'(t_got), 32'hA5);
    chk("tmo_exp", 32'(t_exp), 32'd0);
    chk("tmo_recv", 32'(t_recv), 32'd0);
    chk("tmo_stall", 32'(t_stall), 32'd0);
    chk("tmo_done", 32'(t_done), 32'd0);
    chk("tmo_ready_low", 32'(t_ready), 32'd0);

    // 4-bit data wrap, always ready, 40 consecutive beats
    v = 0;
    w_valid = 1'b1;
    w_data = 4'd0;
    w_start = 1'b1;
    tick();
    w_start = 1'b0;
    k = 0;
    while (!w_done && !w_error && k < 100) begin
      chk("w4_ready", 32'(w_ready), 32'd1);
      hs = w_valid & w_ready;
      tick();
      if (hs) begin
        v++;
        w_data = 4'(v);
      end
      k++;
    end
    chk("w4_done", 32'(w_done), 32'd1);
    chk("w4_cycles", k, 32'd40);
    chk("w4_recv", 32'(w_recv), 32'd40);
    chk("w4_error", 32'(w_error), 32'd0);
    chk("w4_code", 32'(w_code), 32'd0);
    chk("w4_stall", 32'(w_stall), 32'd0);
    chk("w4_got", 32'(w_got), 32'd0);
    chk("w4_exp", 32'(w_exp), 32'd0);
    chk("w4_busy", 32'(w_busy), 32'd0);

    // start inside RUN is ignored, then asynchronous reset mid-run
    d_valid = 1'b1;
    d_data = 8'd0;
    d_start = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      d_data = 8'(i);
      d_start = (i == 2);
      tick();
    end
    d_start = 1'b0;
    chk("restart_ignored_recv", 32'(d_recv), 32'd4);
    chk("restart_ignored_busy", 32'(d_busy), 32'd1);
    reset = 1'b1;
    #1;
    chk("async_ready", 32'(d_ready), 32'd0);
    chk("async_busy", 32'(d_busy), 32'd0);
    chk("async_recv", 32'(d_recv), 32'd0);
    chk("async_stall", 32'(d_stall), 32'd0);
    tick();
    reset = 1'b0;
    tick();
    chk("post_rst_done", 32'(d_done), 32'd0);
    chk("post_rst_error", 32'(d_error), 32'd0);
    chk("post_rst_code", 32'(d_code), 32'd0);
    chk("post_rst_t_code", 32'(t_code), 32'd0);
    chk("post_rst_w_recv", 32'(w_recv), 32'd0);
    run_def(k);
    chk("rerun_done", 32'(d_done), 32'd1);
    chk("rerun_cycles", k, 32'd32);
    chk("rerun_recv", 32'(d_recv), 32'd20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
